// File: rtl/sched_dispatch_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the dispatch controller
// that sits between the task sources, the round-robin arbiter and the core.
package sched_dispatch_ctrl_pkg;

   // Requester count is tied to the width of the external tree arbiter
   localparam int N_REQ   = 16;
   localparam int IDX_W   = 4;
   localparam int SLICE_W = 8;

   // Controller state encoding
   localparam int STATE_W = 2;
   localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [STATE_W-1:0] ST_ARB   = 2'd1;
   localparam logic [STATE_W-1:0] ST_OFFER = 2'd2;
   localparam logic [STATE_W-1:0] ST_RUN   = 2'd3;

   typedef logic [N_REQ-1:0]   req_vec_t;
   typedef logic [IDX_W-1:0]   req_idx_t;
   typedef logic [SLICE_W-1:0] slice_t;

   // Expand a requester index into a one-hot requester vector
   function automatic req_vec_t onehot_from_index(input req_idx_t idx);
      req_vec_t vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/sched_dispatch_ctrl_slice.sv
// Time-slice timer for the running task. Loaded with the slice length when
// the core accepts an offer, counts run cycles starting from 1, and flags
// expiry when the count reaches the slice. A slice of 0 never expires.
module sched_slice_timer
   import sched_dispatch_ctrl_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  logic   run,
   input  slice_t slice_len,
   output logic   expire
);

   slice_t count;
   slice_t slice;
   logic   unlimited;
   logic   at_max;

   assign unlimited = (slice == '0);
   assign at_max    = (count == {SLICE_W{1'b1}});
   assign expire    = run && !unlimited && (count == slice);

   // Latch the slice on load; otherwise count run cycles, holding at the
   // top value so long unlimited tasks never wrap back into a compare window
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         slice <= '0;
      end else if (load) begin
         count <= slice_t'(1);
         slice <= slice_len;
      end else if (run && !expire && !at_max) begin
         count <= count + slice_t'(1);
      end
   end

endmodule

// File: rtl/sched_dispatch_ctrl.sv
// Dispatch front end: collects level requests into a pending mask, shows
// that mask to the external arbiter for exactly one cycle per decision,
// offers the winner to the core, polices its time slice and reports either
// completion (ack) or pre-emption (task put back into pending).
module sched_dispatch_ctrl
   import sched_dispatch_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req,
   input  logic [SLICE_W-1:0]  slice_len,
   output logic [N_REQ-1:0]    arb_req,
   input  logic [IDX_W-1:0]    arb_grant_index,
   input  logic                arb_valid,
   output logic                disp_valid,
   output logic [IDX_W-1:0]    disp_index,
   input  logic                disp_ready,
   input  logic                core_done,
   output logic [N_REQ-1:0]    ack,
   output logic                preempt,
   output logic                busy
);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_next;

   req_vec_t pending;
   req_vec_t pending_next;
   req_vec_t run_mask;
   req_vec_t clr_mask;
   req_vec_t requeue_mask;
   req_vec_t cur_onehot;

   logic in_flight;
   logic in_arb;
   logic in_offer;
   logic in_run;
   logic win;
   logic run_done;
   logic slice_expire;
   logic do_preempt;
   logic timer_load;

   assign in_arb     = (state == ST_ARB);
   assign in_offer   = (state == ST_OFFER);
   assign in_run     = (state == ST_RUN);
   assign in_flight  = in_offer || in_run;
   assign win        = in_arb && arb_valid;
   assign run_done   = in_run && core_done;
   assign do_preempt = in_run && !core_done && slice_expire;
   assign timer_load = in_offer && disp_ready;
   assign cur_onehot = onehot_from_index(disp_index);

   sched_slice_timer u_slice_timer (
      .clk       (clk),
      .rst       (rst),
      .load      (timer_load),
      .run       (in_run),
      .slice_len (slice_len),
      .expire    (slice_expire)
   );

   // Build the masks that shape the pending update: the in-flight task's
   // own request is ignored, the arbiter winner is removed, and a pre-empted
   // task is put back even if its requester has since let go
   always_comb begin
      run_mask     = '0;
      clr_mask     = '0;
      requeue_mask = '0;
      if (in_flight) begin
         run_mask = cur_onehot;
      end
      if (win) begin
         clr_mask = onehot_from_index(arb_grant_index);
      end
      if (do_preempt) begin
         requeue_mask = cur_onehot;
      end
      pending_next = (pending | (req & ~run_mask) | requeue_mask) & ~clr_mask;
   end

   // Next-state selection; completion beats slice expiry in the same cycle
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (pending != '0) begin
               state_next = ST_ARB;
            end
         end
         ST_ARB: begin
            if (arb_valid) begin
               state_next = ST_OFFER;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_OFFER: begin
            if (disp_ready) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (core_done || slice_expire) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Controller state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Pending request mask
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end

   // Capture the arbiter winner; held stable through OFFER and RUN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_index <= '0;
      end else if (win) begin
         disp_index <= arb_grant_index;
      end
   end

   // Registered one-cycle completion and pre-emption pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack     <= '0;
         preempt <= 1'b0;
      end else begin
         ack     <= run_done ? cur_onehot : '0;
         preempt <= do_preempt;
      end
   end

   // The arbiter only sees requests during the single decision cycle so its
   // rotating priority advances once per dispatch
   assign arb_req    = in_arb ? pending : '0;
   assign disp_valid = in_offer;
   assign busy       = in_flight;

endmodule

// File: tb/tb_sched_dispatch_ctrl.sv
// Self-checking bench for sched_dispatch_ctrl with a behavioural
// round-robin arbiter, a scripted core and a queue-based scoreboard.
module tb_sched_dispatch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] req;
   logic [7:0]  slice_len;
   logic [15:0] arb_req;
   logic [3:0]  arb_grant_index;
   logic        arb_valid;
   logic        disp_valid;
   logic [3:0]  disp_index;
   logic        disp_ready;
   logic        core_done;
   logic [15:0] ack;
   logic        preempt;
   logic        busy;

   typedef struct {
      bit is_ack;
      int idx;
      int due;
   } out_t;

   out_t out_q[$];
   int   disp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_win = 15;
   logic [3:0] arb_ptr;
   logic       arb_found;

   sched_dispatch_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .req             (req),
      .slice_len       (slice_len),
      .arb_req         (arb_req),
      .arb_grant_index (arb_grant_index),
      .arb_valid       (arb_valid),
      .disp_valid      (disp_valid),
      .disp_index      (disp_index),
      .disp_ready      (disp_ready),
      .core_done       (core_done),
      .ack             (ack),
      .preempt         (preempt),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   // Cycle counter used to time-stamp expected responses
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural round-robin arbiter: first request after the last winner
   always_comb begin
      arb_grant_index = 4'd0;
      arb_found       = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         if (!arb_found && arb_req[(int'(arb_ptr) + k) % 16]) begin
            arb_grant_index = 4'((int'(arb_ptr) + k) % 16);
            arb_found       = 1'b1;
         end
      end
   end
   assign arb_valid = (arb_req != 16'h0);

   // Arbiter priority advances on every cycle it sees a request
   always @(posedge clk or posedge rst) begin
      if (rst) arb_ptr <= 4'd15;
      else if (arb_req != 16'h0) arb_ptr <= arb_grant_index;
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   function automatic int next_idx(input logic [15:0] mask, input int last);
      for (int k = 1; k <= 16; k++) begin
         if (mask[(last + k) % 16]) return (last + k) % 16;
      end
      return 0;
   endfunction

   // Monitor: compares handshakes and ack/preempt pulses against the queues
   always @(negedge clk) begin : monitor
      out_t e;
      logic [15:0] exp_ack;
      if (!rst) begin
         if (disp_valid && disp_ready) begin
            check_output("dispatch_queued", 32'(disp_q.size() != 0), 32'd1);
            if (disp_q.size() != 0) check_output("dispatch_index", disp_index, disp_q.pop_front());
         end
         if (out_q.size() != 0 && cyc == out_q[0].due) begin
            e = out_q.pop_front();
            exp_ack = e.is_ack ? (16'h1 << e.idx) : 16'h0;
            check_output("ack_value", ack, exp_ack);
            check_output("preempt_value", preempt, !e.is_ack);
         end else begin
            check_output("no_stray_out", {ack != 16'h0, preempt}, 2'b00);
         end
      end
   end

   // Serve one dispatch: optional backpressure, then done after d run cycles
   // or pre-emption after s cycles when the slice is shorter than the task
   task automatic serve(input int ready_wait, input int d, input int s, input int exp_idx,
                        input bit drop_req, input bit stray_done);
      int n;
      int hs;
      n = 0;
      while (!disp_valid && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check_output("offer_seen", disp_valid, 1'b1);
      if (!disp_valid) return;
      if (drop_req) req = 16'h0;
      check_output("offer_index", disp_index, exp_idx);
      for (int i = 0; i < ready_wait; i++) begin
         if (stray_done && i == 2) core_done = 1'b1;
         @(posedge clk); #1;
         core_done = 1'b0;
         check_output("offer_hold", {disp_valid, disp_index}, {1'b1, 4'(exp_idx)});
      end
      slice_len  = 8'(s);
      disp_q.push_back(exp_idx);
      disp_ready = 1'b1;
      hs = cyc;
      @(posedge clk); #1;
      disp_ready = 1'b0;
      slice_len  = 8'($urandom_range(1, 255));
      check_output("run_entry", {busy, disp_valid}, 2'b10);
      if (s == 0 || d <= s) begin
         out_q.push_back('{is_ack: 1'b1, idx: exp_idx, due: hs + 1 + d});
         for (int k = 1; k < d; k++) begin
            @(posedge clk); #1;
         end
         core_done = 1'b1;
         @(posedge clk); #1;
         core_done = 1'b0;
      end else begin
         out_q.push_back('{is_ack: 1'b0, idx: exp_idx, due: hs + 1 + s});
         for (int k = 1; k <= s; k++) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic idle_check(input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clk); #1;
         check_output("idle_quiet", {busy, disp_valid, arb_req != 16'h0}, 3'b000);
      end
   endtask

   // Hold a request mask for a number of dispatches, then drop it while an
   // offer is up and drain whatever was already latched as pending
   task automatic apply_stimulus(input logic [15:0] mask, input int count, input bit rand_mode);
      logic [15:0] rem;
      int idx;
      int s;
      int d;
      int rw;
      req = mask;
      for (int j = 0; j < count; j++) begin
         idx = next_idx(mask, last_win);
         s   = rand_mode ? int'($urandom_range(0, 6)) : 0;
         d   = rand_mode ? int'($urandom_range(1, 8)) : 1;
         rw  = rand_mode ? int'($urandom_range(0, 3)) : 0;
         serve(rw, d, s, idx, 1'b0, 1'b0);
         last_win = idx;
      end
      idx = next_idx(mask, last_win);
      serve(1, 2, 0, idx, 1'b1, 1'b0);
      last_win = idx;
      rem = mask;
      rem[idx] = 1'b0;
      while (rem != 16'h0) begin
         idx = next_idx(rem, last_win);
         serve(0, 1, 0, idx, 1'b0, 1'b0);
         last_win = idx;
         rem[idx] = 1'b0;
      end
      idle_check(4);
   endtask

   initial begin
      logic [15:0] m;
      int n;
      rst        = 1'b1;
      req        = 16'h0;
      slice_len  = 8'h0;
      disp_ready = 1'b0;
      core_done  = 1'b0;
      #2;
      check_output("reset_outputs", {arb_req, ack, preempt, busy, disp_valid, disp_index}, 39'h0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      idle_check(2);

      // Single requester with latency check
      req = 16'h0004;
      for (int e = 1; e <= 3; e++) begin
         @(posedge clk); #1;
         check_output("offer_latency", disp_valid, (e == 3));
      end
      serve(0, 5, 0, 2, 1'b1, 1'b0);
      last_win = 2;
      idle_check(4);

      // Fairness: everyone requesting, 32 dispatches
      apply_stimulus(16'hFFFF, 32, 1'b0);

      // Pre-emption then re-dispatch of the same requester
      req = 16'h0001;
      serve(0, 99, 4, 0, 1'b0, 1'b0);
      serve(0, 2, 0, 0, 1'b1, 1'b0);
      last_win = 0;
      idle_check(4);

      // Done and slice expiry in the same cycle
      req = 16'h0010;
      serve(0, 3, 3, 4, 1'b1, 1'b0);
      last_win = 4;
      idle_check(4);

      // Backpressure with request withdrawn and a stray done during OFFER
      req = 16'h0080;
      serve(10, 2, 0, 7, 1'b1, 1'b1);
      last_win = 7;
      idle_check(4);

      // Randomised masks, slices and run lengths
      for (int p = 0; p < 4; p++) begin
         m = 16'($urandom());
         if (m == 16'h0) m = 16'h0001;
         apply_stimulus(m, 6, 1'b1);
      end

      // Reset while running
      req       = 16'h0020;
      slice_len = 8'h0;
      n = 0;
      while (!disp_valid && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check_output("offer_seen_rst", disp_valid, 1'b1);
      disp_q.push_back(next_idx(16'h0020, last_win));
      disp_ready = 1'b1;
      @(posedge clk); #1;
      disp_ready = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      check_output("running_before_rst", busy, 1'b1);
      rst = 1'b1;
      #1;
      check_output("rst_mid_run", {ack, preempt, disp_valid, busy, arb_req}, 35'h0);
      req = 16'h0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      last_win = 15;
      idle_check(6);

      check_output("out_q_drained", out_q.size(), 0);
      check_output("disp_q_drained", disp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
